// File: rtl/commu_pkg.sv
// Shared constants and state encodings for the commu serial link (rx and tx sides).
package commu_pkg;
  localparam int          WORD_BITS = 16;
  localparam logic [15:0] HEAD_WORD = 16'hEB90;
  localparam logic [15:0] TAIL_WORD = 16'h0D0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_CHK  = 2'd2,
    ST_TAIL = 2'd3
  } frm_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } inf_state_e;
endpackage

// File: rtl/commu_rx_inf.sv
// commu line receiver: 2-flop sync, start detect, bit timer and shift register.
// Recovers start + 16 data bits (LSB first) + stop; word_vld/word_err are 1-cycle pulses.
module commu_rx_inf (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        rx_a,
  input  logic [19:0] tbit_period,
  output logic [15:0] word_q,
  output logic        word_vld,
  output logic        word_err,
  output logic        line_busy
);
  import commu_pkg::*;

  logic       sync1_q, sync2_q, prev_q;
  inf_state_e st_q, st_d;
  logic [19:0] tmr_q, tmr_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shf_q, shf_d;
  logic        vld_d, err_d;
  logic        enable;
  logic        fall;

  assign enable = (tbit_period >= 20'd4);
  assign fall   = prev_q & ~sync2_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
    end else begin
      sync1_q <= rx_a;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    bit_d = bit_q;
    shf_d = shf_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    if (!enable) begin
      st_d = RX_IDLE;
    end else begin
      case (st_q)
        RX_IDLE: begin
          if (fall) begin
            st_d  = RX_START;
            tmr_d = (tbit_period >> 1) - 20'd1;
          end
        end
        RX_START: begin
          if (tmr_q == '0) begin
            // line back high at mid-start: treat as a glitch
            if (sync2_q) begin
              st_d = RX_IDLE;
            end else begin
              st_d  = RX_DATA;
              tmr_d = tbit_period - 20'd1;
              bit_d = '0;
            end
          end else begin
            tmr_d = tmr_q - 20'd1;
          end
        end
        RX_DATA: begin
          if (tmr_q == '0) begin
            shf_d = {sync2_q, shf_q[15:1]};
            tmr_d = tbit_period - 20'd1;
            if (bit_q == 4'd15) st_d = RX_STOP;
            else                bit_d = bit_q + 4'd1;
          end else begin
            tmr_d = tmr_q - 20'd1;
          end
        end
        RX_STOP: begin
          if (tmr_q == '0) begin
            st_d  = RX_IDLE;
            vld_d = sync2_q;
            err_d = ~sync2_q;
          end else begin
            tmr_d = tmr_q - 20'd1;
          end
        end
        default: st_d = RX_IDLE;
      endcase
    end
  end

  assign word_q    = shf_q;
  assign word_vld  = vld_d;
  assign word_err  = err_d;
  assign line_busy = (st_q != RX_IDLE);
endmodule

// File: rtl/commu_rx_frm.sv
// commu receive framer: head / payload / [checksum] / tail, payload split into bytes.
// Checksum word present only when COMMU_RX_CHK_EN is defined.
module commu_rx_frm #(
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        rx_a,
  input  logic [19:0] tbit_period,
  input  logic [15:0] len_pkg,
  output logic [7:0]  rx_data,
  output logic        rx_vld,
  output logic        rx_frm,
  output logic        rx_done,
  output logic        rx_err,
  output logic [7:0]  err_cnt
);
  import commu_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_BITS + 1) + 20;

  logic [15:0] word_q;
  logic        word_vld, word_err, line_busy;

  commu_rx_inf u_inf (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .rx_a        (rx_a),
    .tbit_period (tbit_period),
    .word_q      (word_q),
    .word_vld    (word_vld),
    .word_err    (word_err),
    .line_busy   (line_busy)
  );

  frm_state_e  st_q, st_d;
  logic [15:0] left_q, left_d;
  logic [7:0]  lo_q, lo_d;
  logic        lo_pend_q, lo_pend_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d, frm_q, frm_d, done_q, done_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d, to_load;
  logic [15:0] words_need;
  logic        fail;
`ifdef COMMU_RX_CHK_EN
  logic [15:0] sum_q, sum_d;
`endif

  assign to_load    = TO_W'(TIMEOUT_BITS) * TO_W'(tbit_period);
  assign words_need = (len_pkg >> 1) + {15'd0, len_pkg[0]};

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      left_q    <= '0;
      lo_q      <= '0;
      lo_pend_q <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      frm_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      to_q      <= '0;
`ifdef COMMU_RX_CHK_EN
      sum_q     <= '0;
`endif
    end else begin
      st_q      <= st_d;
      left_q    <= left_d;
      lo_q      <= lo_d;
      lo_pend_q <= lo_pend_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      frm_q     <= frm_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`ifdef COMMU_RX_CHK_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    st_d      = st_q;
    left_d    = left_q;
    lo_d      = lo_q;
    lo_pend_d = 1'b0;
    data_d    = data_q;
    vld_d     = 1'b0;
    frm_d     = frm_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    to_d      = to_q;
    fail      = 1'b0;
`ifdef COMMU_RX_CHK_EN
    sum_d     = sum_q;
`endif

    if (lo_pend_q) begin
      data_d = lo_q;
      vld_d  = 1'b1;
    end

    // timer restarts whenever a word is in flight; only idle line time counts
    if (st_q == ST_IDLE || line_busy) to_d = to_load;
    else if (to_q == '0)              fail = 1'b1;
    else                              to_d = to_q - TO_W'(1);

    case (st_q)
      ST_IDLE: begin
        if (word_vld && word_q == HEAD_WORD) begin
          left_d = words_need;
          st_d   = (words_need == '0) ? ST_TAIL : ST_PAY;
`ifdef COMMU_RX_CHK_EN
          sum_d  = '0;
`endif
        end
      end
      ST_PAY: begin
        if (word_vld) begin
          data_d = word_q[15:8];
          vld_d  = 1'b1;
          frm_d  = 1'b1;
          lo_d   = word_q[7:0];
          left_d = left_q - 16'd1;
`ifdef COMMU_RX_CHK_EN
          sum_d  = sum_q + word_q;
`endif
          if (left_q == 16'd1) begin
            lo_pend_d = ~len_pkg[0];
`ifdef COMMU_RX_CHK_EN
            st_d = ST_CHK;
`else
            st_d = ST_TAIL;
`endif
          end else begin
            lo_pend_d = 1'b1;
          end
        end
      end
`ifdef COMMU_RX_CHK_EN
      ST_CHK: begin
        if (word_vld) begin
          if (word_q == sum_q) st_d = ST_TAIL;
          else                 fail = 1'b1;
        end
      end
`endif
      ST_TAIL: begin
        if (word_vld) begin
          if (word_q == TAIL_WORD) begin
            done_d = 1'b1;
            frm_d  = 1'b0;
            st_d   = ST_IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (word_err && st_q != ST_IDLE) fail = 1'b1;

    if (fail) begin
      err_d     = 1'b1;
      frm_d     = 1'b0;
      vld_d     = 1'b0;
      lo_pend_d = 1'b0;
      st_d      = ST_IDLE;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  assign rx_data = data_q;
  assign rx_vld  = vld_q;
  assign rx_frm  = frm_q;
  assign rx_done = done_q;
  assign rx_err  = err_q;
  assign err_cnt = cnt_q;
endmodule

// File: tb/tb_commu_rx_frm.sv
// Directed self-checking bench for commu_rx_frm at tbit_period=8.
// Build with COMMU_RX_CHK_EN defined to exercise the checksum word.
module tb_commu_rx_frm;
  localparam int TBIT = 8;
  localparam logic [15:0] HEAD = 16'hEB90;
  localparam logic [15:0] TAIL = 16'h0D0A;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        rx_a;
  logic [19:0] tbit_period;
  logic [15:0] len_pkg;
  logic [7:0]  rx_data;
  logic        rx_vld, rx_frm, rx_done, rx_err;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_err  = 0;
  int bad_frm = 0;
  int bad_ovl = 0;
  logic [7:0] byte_q[$];

  commu_rx_frm dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .rx_a        (rx_a),
    .tbit_period (tbit_period),
    .len_pkg     (len_pkg),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .rx_frm      (rx_frm),
    .rx_done     (rx_done),
    .rx_err      (rx_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (rx_vld) begin
      byte_q.push_back(rx_data);
      if (!rx_frm) bad_frm++;
    end
    if (rx_done) n_done++;
    if (rx_err)  n_err++;
    if ((rx_vld && (rx_done || rx_err)) || (rx_done && rx_err)) bad_ovl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_sys);
    rx_a = b;
    repeat (TBIT - 1) @(negedge clk_sys);
  endtask

  task automatic send_word(input logic [15:0] w, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
    send_bit(stop_b);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1, input int nw,
                            input logic [15:0] tail_w);
`ifdef COMMU_RX_CHK_EN
    logic [15:0] s;
    s = 16'h0;
`endif
    send_word(HEAD, 1'b1);
    if (nw > 0) send_word(w0, 1'b1);
    if (nw > 1) send_word(w1, 1'b1);
`ifdef COMMU_RX_CHK_EN
    if (nw > 0) s = s + w0;
    if (nw > 1) s = s + w1;
    send_word(s, 1'b1);
`endif
    send_word(tail_w, 1'b1);
    repeat (4) @(negedge clk_sys);
  endtask

  initial begin
    int d0, e0, waited;
    rst = 1'b1;
    rx_a = 1'b1;
    tbit_period = 20'(TBIT);
    len_pkg = 16'd4;
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    check("reset_outs", {24'd0, rx_vld, rx_frm, rx_done, rx_err, 4'd0}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_errcnt", {24'd0, err_cnt}, 32'd0);

    // 1: four-byte frame
    byte_q.delete(); d0 = n_done; e0 = n_err;
    send_frame(16'h1234, 16'h5678, 2, TAIL);
    check("t1_nbytes", byte_q.size(), 4);
    if (byte_q.size() == 4)
      check("t1_bytes", {byte_q[0], byte_q[1], byte_q[2], byte_q[3]}, 32'h12345678);
    check("t1_done", n_done - d0, 1);
    check("t1_err", n_err - e0, 0);
    check("t1_frm_low", {31'd0, rx_frm}, 0);

    // 2: odd length drops last low byte
    len_pkg = 16'd3;
    byte_q.delete(); d0 = n_done;
    send_frame(16'hAABB, 16'hCC00, 2, TAIL);
    check("t2_nbytes", byte_q.size(), 3);
    if (byte_q.size() == 3)
      check("t2_bytes", {8'd0, byte_q[0], byte_q[1], byte_q[2]}, 32'h00AABBCC);
    check("t2_done", n_done - d0, 1);

    // 3: bad tail, then recovery
    len_pkg = 16'd4;
    d0 = n_done; e0 = n_err;
    send_frame(16'h1234, 16'h5678, 2, 16'h0D0B);
    check("t3_err", n_err - e0, 1);
    check("t3_no_done", n_done - d0, 0);
    check("t3_errcnt", {24'd0, err_cnt}, 1);
    d0 = n_done;
    send_frame(16'h0102, 16'h0304, 2, TAIL);
    check("t3_recover_done", n_done - d0, 1);

    // 4: stop-bit error in payload, then in IDLE
    e0 = n_err; byte_q.delete();
    send_word(HEAD, 1'b1);
    send_word(16'h1234, 1'b0);
    repeat (4) @(negedge clk_sys);
    check("t4_err", n_err - e0, 1);
    check("t4_errcnt", {24'd0, err_cnt}, 2);
    check("t4_nbytes", byte_q.size(), 0);
    e0 = n_err;
    send_word(16'h1234, 1'b0);
    repeat (20) @(negedge clk_sys);
    check("t4_idle_noerr", n_err - e0, 0);

    // 5: timeout after head, then short glitch in IDLE
    e0 = n_err;
    send_word(HEAD, 1'b1);
    waited = 0;
    while (n_err == e0 && waited < 700) begin
      @(negedge clk_sys);
      waited++;
    end
    check("t5_timeout_err", n_err - e0, 1);
    check("t5_timeout_window", {31'd0, (waited >= 480 && waited <= 530)}, 1);
    check("t5_errcnt", {24'd0, err_cnt}, 3);
    e0 = n_err; d0 = n_done; byte_q.delete();
    @(negedge clk_sys);
    rx_a = 1'b0;
    repeat (3) @(negedge clk_sys);
    rx_a = 1'b1;
    repeat (200) @(negedge clk_sys);
    check("t5_glitch_quiet", {n_err - e0, n_done - d0, byte_q.size()}, 0);

`ifdef COMMU_RX_CHK_EN
    // 6: checksum good / bad
    d0 = n_done; e0 = n_err;
    send_frame(16'h0001, 16'hFFFF, 2, TAIL);
    check("t6_chk_good_done", n_done - d0, 1);
    d0 = n_done;
    send_word(HEAD, 1'b1);
    send_word(16'h0001, 1'b1);
    send_word(16'hFFFF, 1'b1);
    send_word(16'h0001, 1'b1);
    send_word(TAIL, 1'b1);
    repeat (4) @(negedge clk_sys);
    check("t6_chk_bad_err", n_err - e0, 1);
    check("t6_chk_bad_nodone", n_done - d0, 0);
    check("t6_errcnt", {24'd0, err_cnt}, 4);
`endif

    check("no_overlap", bad_ovl, 0);
    check("vld_inside_frm", bad_frm, 0);

    // reset during payload
    send_word(HEAD, 1'b1);
    send_word(16'h1234, 1'b1);
    check("rst_pre_frm", {31'd0, rx_frm}, 1);
    rst = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_outs", {rx_data, 4'd0, rx_vld, rx_frm, rx_done, rx_err, err_cnt}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
